// File: rtl/iscas_cascade_timer_if.sv
// Control/status bundle for iscas_cascade_timer: G0/G1/G2 controls in, channel values and flags out.
// The master side drives the controls; the slave side is the timer itself.
interface iscas_cascade_timer_if #(
  parameter int CH    = 3,
  parameter int CNT_W = 4
);
  logic                  G0;
  logic                  G1;
  logic                  G2;
  logic [CH*CNT_W-1:0]   cnt_o;
  logic [CH-1:0]         tc_o;
  logic                  done;
  logic                  ovf;
  logic                  busy;

  modport master (output G0, G1, G2, input cnt_o, tc_o, done, ovf, busy);
  modport slave  (input G0, G1, G2, output cnt_o, tc_o, done, ovf, busy);
endinterface

// File: rtl/iscas_cascade_timer.sv
// Cascaded CH x CNT_W up/down counter/timer with pause/resume FSM, terminal-count pulses,
// sticky full-chain overflow and a fixed cool-down after every full-chain wrap.
module iscas_cascade_timer #(
  parameter int          CH       = 3,
  parameter int          CNT_W    = 4,
  parameter int unsigned TC_VAL   = (1 << CNT_W) - 1,
  parameter int          HOLD_CYC = 2
) (
  input  logic                  blif_clk_net,
  input  logic                  blif_reset_net,
  iscas_cascade_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, COOL} state_t;

  localparam logic [CNT_W-1:0] END_UP   = CNT_W'(TC_VAL);
  localparam logic [3:0]       COOL_LST = 4'(HOLD_CYC - 1);

  state_t           state;
  logic [3:0]       cool_cnt;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]    wrap;
  logic [CH-1:0]    tc_q;
  logic             done_q;
  logic             ovf_q;
  logic             step;

  assign step = (state == RUN) && bus.G1;

  // Ripple the step through the chain: a channel advances only when every lower channel sits at
  // its end value, so the carry into channel k+1 is exactly "channel k wrapped".
  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin : chain
    logic carry;
    logic at_end;
    carry = step;
    for (int k = 0; k < CH; k++) begin
      at_end   = bus.G2 ? (cnt_q[k] == '0) : (cnt_q[k] == END_UP);
      wrap[k]  = carry && at_end;
      cnt_d[k] = cnt_q[k];
      if (carry) begin
        if (at_end) cnt_d[k] = bus.G2 ? END_UP : '0;
        else        cnt_d[k] = bus.G2 ? cnt_q[k] - CNT_W'(1) : cnt_q[k] + CNT_W'(1);
      end
      carry = wrap[k];
    end
  end

  // NOTE: reset is sampled synchronously, so it stays out of the sensitivity list; state updates
  // use non-blocking assignments so every register sees pre-edge values of its neighbours.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net || bus.G0) begin
      state    <= IDLE;
      cool_cnt <= '0;
      tc_q     <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) cnt_q[k] <= cnt_d[k];
      tc_q   <= wrap;
      done_q <= wrap[CH-1];
      if (wrap[CH-1]) ovf_q <= 1'b1;

      unique case (state)
        IDLE:  if (bus.G1) state <= RUN;
        RUN: begin
          if (!bus.G1) begin
            state <= PAUSE;
          end else if (wrap[CH-1]) begin
            state    <= COOL;
            cool_cnt <= '0;
          end
        end
        PAUSE: if (bus.G1) state <= RUN;
        COOL: begin
          // Leave on the HOLD_CYC-th edge after the wrap edge.
          if (cool_cnt == COOL_LST) begin
            state    <= bus.G1 ? RUN : IDLE;
            cool_cnt <= '0;
          end else begin
            cool_cnt <= cool_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cnt_o = '0;
    for (int k = 0; k < CH; k++) bus.cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign bus.tc_o = tc_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_iscas_cascade_timer.sv
// Scoreboard bench for iscas_cascade_timer (CH=2, CNT_W=2, TC_VAL=3, HOLD_CYC=2): a base-(TC_VAL+1)
// integer model pushes the expected outputs for each edge, and each scenario pops and compares.
module tb_iscas_cascade_timer;

  localparam int CH       = 2;
  localparam int CNT_W    = 2;
  localparam int TC_VAL   = 3;
  localparam int HOLD_CYC = 2;
  localparam int NB       = TC_VAL + 1;
  localparam int TOTAL    = NB ** CH;

  typedef struct packed {
    logic [CH*CNT_W-1:0] cnt;
    logic [CH-1:0]       tc;
    logic                done;
    logic                ovf;
    logic                busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iscas_cascade_timer_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

  iscas_cascade_timer #(
    .CH(CH), .CNT_W(CNT_W), .TC_VAL(TC_VAL), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t sb [$];

  // Reference model: whole chain held as one integer in base NB; 0 idle, 1 run, 2 pause, 3 cool.
  int          m_val, m_state, m_cool;
  logic [CH-1:0] m_tc;
  logic        m_done, m_ovf;

  function automatic obs_t model_obs();
    obs_t o;
    int   v;
    v = m_val;
    o.cnt = '0;
    for (int k = 0; k < CH; k++) begin
      o.cnt[k*CNT_W +: CNT_W] = CNT_W'(v % NB);
      v = v / NB;
    end
    o.tc   = m_tc;
    o.done = m_done;
    o.ovf  = m_ovf;
    o.busy = (m_state != 0);
    return o;
  endfunction

  task automatic model_edge(input logic r, input logic g0, input logic g1, input logic g2);
    logic step;
    if (r || g0) begin
      m_val = 0; m_state = 0; m_cool = 0; m_tc = '0; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      step = (m_state == 1) && g1;
      m_tc = '0;
      if (step) begin
        for (int k = 0; k < CH; k++) begin
          if (!g2) m_tc[k] = ((m_val + 1) % (NB ** (k + 1))) == 0;
          else     m_tc[k] = (m_val % (NB ** (k + 1))) == 0;
        end
        m_val = g2 ? (m_val + TOTAL - 1) % TOTAL : (m_val + 1) % TOTAL;
      end
      m_done = m_tc[CH-1];
      if (m_done) m_ovf = 1'b1;
      case (m_state)
        0: if (g1) m_state = 1;
        1: begin
          if (!g1) m_state = 2;
          else if (m_done) begin m_state = 3; m_cool = 0; end
        end
        2: if (g1) m_state = 1;
        default: begin
          if (m_cool == HOLD_CYC - 1) begin m_state = g1 ? 1 : 0; m_cool = 0; end
          else m_cool++;
        end
      endcase
    end
  endtask

  // Drive one edge's inputs, record the model's expectation, then sample just after the edge.
  task automatic tick(input logic r, input logic g0, input logic g1, input logic g2);
    rst    = r;
    bus.G0 = g0;
    bus.G1 = g1;
    bus.G2 = g2;
    model_edge(r, g0, g1, g2);
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t dut_obs();
    return {bus.cnt_o, bus.tc_o, bus.done, bus.ovf, bus.busy};
  endfunction

  task automatic test_reset();
    obs_t exp, got;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset_zero: got %h expected 0", got);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    exp = sb.pop_front(); got = dut_obs(); n_cmp++;
    if (got !== exp || got.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h busy=1", got, exp);
    end
  endtask

  // Continues from test_reset: RUN entered on edge 1, steps on edges 2..17, cool-down 18..19.
  task automatic test_up_cascade();
    obs_t exp, got;
    for (int e = 2; e <= 20; e++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL up_edge%0d: got %h expected %h", e, got, exp);
      end
      if (e == 5 || e == 9 || e == 13) begin
        n_cmp++;
        if (got.tc !== 2'b01) begin
          n_fail++; $display("FAIL up_tc0_edge%0d: got %b expected 01", e, got.tc);
        end
      end
      if (e == 17) begin
        n_cmp++;
        if (got !== obs_t'({4'd0, 2'b11, 1'b1, 1'b1, 1'b1})) begin
          n_fail++; $display("FAIL up_full_wrap: got %h expected cnt=0 tc=11 done=1 ovf=1", got);
        end
      end
      if (e == 19 || e == 20) begin
        n_cmp++;
        if (got.cnt !== ((e == 20) ? 4'd1 : 4'd0)) begin
          n_fail++; $display("FAIL up_cool_edge%0d: got cnt=%0d expected %0d", e, got.cnt, (e == 20) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_down_mode();
    obs_t exp, got;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    void'(sb.pop_front());
    for (int s = 1; s <= 19; s++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL down_edge%0d: got %h expected %h", s, got, exp);
      end
      if (s == 1) begin
        n_cmp++;
        if (got.cnt !== 4'hF || got.tc[0] !== 1'b1) begin
          n_fail++; $display("FAIL down_first_step: got cnt=%h tc=%b expected cnt=f tc[0]=1", got.cnt, got.tc);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    obs_t exp, got;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    n_cmp++;
    if (bus.cnt_o !== 4'd5) begin
      n_fail++; $display("FAIL pause_setup: got cnt=%0d expected 5", bus.cnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp || got.cnt !== 4'd5 || got.busy !== 1'b1) begin
        n_fail++; $display("FAIL pause_hold[%0d]: got %h expected %h", i, got, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp || got.cnt !== ((i == 1) ? 4'd6 : 4'd5)) begin
        n_fail++; $display("FAIL resume[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_clear_priority();
    obs_t exp, got;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 18; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    n_cmp++;
    if (bus.ovf !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL clear_setup: got ovf=%b busy=%b expected 1 1", bus.ovf, bus.busy);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    exp = sb.pop_front(); got = dut_obs(); n_cmp++;
    if (got !== exp || got !== obs_t'(0)) begin
      n_fail++; $display("FAIL clear_mid_cool: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL clear_rerun[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_direction_change();
    obs_t exp, got;
    logic dir_seq [4];
    logic [3:0] cnt_seq [4];
    dir_seq = '{1'b0, 1'b0, 1'b1, 1'b0};
    cnt_seq = '{4'd1, 4'd2, 4'd1, 4'd2};
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1, dir_seq[i]);
      exp = sb.pop_front(); got = dut_obs(); n_cmp++;
      if (got !== exp || got.cnt !== cnt_seq[i] || got.tc !== 2'b00) begin
        n_fail++; $display("FAIL dir_change[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    bus.G0 = 1'b0;
    bus.G1 = 1'b0;
    bus.G2 = 1'b0;
    m_val = 0; m_state = 0; m_cool = 0; m_tc = '0; m_done = 1'b0; m_ovf = 1'b0;
    #2;
    test_reset();
    test_up_cascade();
    test_down_mode();
    test_pause_resume();
    test_clear_priority();
    test_direction_change();
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
